// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA sync / data-enable generator.
// Produces h_sync, v_sync and de from configurable porch/sync/active
// timings with a pixel-clock divider, exports x/y to an upstream pixel
// source and returns its colour blanked and aligned with the syncs.
// Optional feature macro: VGA_TEST_PATTERN_EN (internal colour bars
// selected by pattern_sel); when undefined, pattern_sel is ignored.
module vga_timing_gen #(
    parameter int COLOR_W  = 8,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CLK_DIV  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               pattern_sel,
    input  logic [COLOR_W-1:0] pix_r_in,
    input  logic [COLOR_W-1:0] pix_g_in,
    input  logic [COLOR_W-1:0] pix_b_in,
    output logic [11:0]        x,
    output logic [11:0]        y,
    output logic               de_req,
    output logic               h_sync,
    output logic               v_sync,
    output logic               de,
    output logic               frame_start,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    // Window bounds are 13 bits so an active width of 4096 still compares correctly.
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    logic [DIV_W-1:0]   div_cnt;
    logic [11:0]        h_cnt, v_cnt;
    logic [12:0]        h_ext, v_ext;
    logic               tick, h_last, v_last, hs_raw, vs_raw;
    logic [COLOR_W-1:0] src_r, src_g, src_b;

    assign tick   = en && (div_cnt == DIV_LAST);
    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);
    assign h_ext  = {1'b0, h_cnt};
    assign v_ext  = {1'b0, v_cnt};
    assign de_req = (h_ext < H_ACT) && (v_ext < V_ACT);
    assign hs_raw = (h_ext >= HS_BEG) && (h_ext < HS_END);
    assign vs_raw = (v_ext >= VS_BEG) && (v_ext < VS_END);
    assign x      = h_cnt;
    assign y      = v_cnt;

`ifdef VGA_TEST_PATTERN_EN
    // Eight equal-width vertical bars across the active area; bar index bits map to {r,g,b}.
    logic [2:0] bar;
    assign bar   = 3'({h_cnt, 3'b000} / 15'(H_ACTIVE));
    assign src_r = pattern_sel ? {COLOR_W{bar[2]}} : pix_r_in;
    assign src_g = pattern_sel ? {COLOR_W{bar[1]}} : pix_g_in;
    assign src_b = pattern_sel ? {COLOR_W{bar[0]}} : pix_b_in;
`else
    logic unused_pattern_sel;
    assign unused_pattern_sel = pattern_sel;
    assign src_r = pix_r_in;
    assign src_g = pix_g_in;
    assign src_b = pix_b_in;
`endif

    // Pixel-clock divider: free-runs 0..CLK_DIV-1 while enabled.
    always_ff @(posedge clk) begin
        if (rst)
            div_cnt <= '0;
        else if (en)
            div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end

    // Horizontal/vertical position counters, advanced once per pixel tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (tick) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last)
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end
    end

    // Output stage: one register behind x/y so syncs, de and colour line up.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_sync <= ~HS_ON;
            v_sync <= ~VS_ON;
            de     <= 1'b0;
            red    <= '0;
            green  <= '0;
            blue   <= '0;
        end else if (en) begin
            h_sync <= hs_raw ? HS_ON : ~HS_ON;
            v_sync <= vs_raw ? VS_ON : ~VS_ON;
            de     <= de_req;
            red    <= de_req ? src_r : '0;
            green  <= de_req ? src_g : '0;
            blue   <= de_req ? src_b : '0;
        end
    end

    // Frame-start strobe: single clk after the (last,last) -> (0,0) wrap; cleared whenever idle.
    always_ff @(posedge clk) begin
        if (rst)
            frame_start <= 1'b0;
        else
            frame_start <= tick && h_last && v_last;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed self-checking bench for vga_timing_gen.
// dut0: H 8/2/3/3, V 4/1/2/1, CLK_DIV=1, active-low syncs.
// dut1: same geometry, CLK_DIV=4, active-high h_sync.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       pattern_sel = 1'b0;
    logic [7:0] pix_r = 8'hA5, pix_g = 8'h3C, pix_b = 8'h5A;

    logic [11:0] x0, y0, x1, y1;
    logic        dr0, hs0, vs0, de0, fs0, dr1, hs1, vs1, de1, fs1;
    logic [7:0]  r0, g0, b0, r1, g1, b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(.COLOR_W(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(0), .VS_POL(0), .CLK_DIV(1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .pix_r_in(pix_r), .pix_g_in(pix_g), .pix_b_in(pix_b),
        .x(x0), .y(y0), .de_req(dr0), .h_sync(hs0), .v_sync(vs0), .de(de0),
        .frame_start(fs0), .red(r0), .green(g0), .blue(b0));

    vga_timing_gen #(.COLOR_W(8), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
                     .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
                     .HS_POL(1), .VS_POL(0), .CLK_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .en(en), .pattern_sel(pattern_sel),
        .pix_r_in(pix_r), .pix_g_in(pix_g), .pix_b_in(pix_b),
        .x(x1), .y(y1), .de_req(dr1), .h_sync(hs1), .v_sync(vs1), .de(de1),
        .frame_start(fs1), .red(r1), .green(g1), .blue(b1));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for 3 clks, then release so the next edge is clk 1.
    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en  = 1'b1;
        repeat (3) step();
        n_cmp++; if (hs0 !== 1'b1) begin n_err++; $display("FAIL reset_hsync got %b exp 1", hs0); end
        n_cmp++; if (vs0 !== 1'b1) begin n_err++; $display("FAIL reset_vsync got %b exp 1", vs0); end
        n_cmp++; if (de0 !== 1'b0) begin n_err++; $display("FAIL reset_de got %b exp 0", de0); end
        n_cmp++; if (fs0 !== 1'b0) begin n_err++; $display("FAIL reset_fs got %b exp 0", fs0); end
        n_cmp++; if (x0 !== 12'd0 || y0 !== 12'd0) begin n_err++; $display("FAIL reset_xy got %0d,%0d exp 0,0", x0, y0); end
        n_cmp++; if (r0 !== 8'h00) begin n_err++; $display("FAIL reset_red got %h exp 00", r0); end
        n_cmp++; if (hs1 !== 1'b0) begin n_err++; $display("FAIL reset_hsync_pol1 got %b exp 0", hs1); end
        rst = 1'b0;
    endtask

    // Two full frames at CLK_DIV=1: position, syncs, de, frame_start per clk.
    task automatic test_frame();
        int hc, ln, pulses, first_pulse;
        logic exp_hs, exp_vs, exp_de, exp_fs, exp_dr;
        pulses = 0;
        first_pulse = -1;
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            step();
            hc = (n - 1) % 16;
            ln = ((n - 1) / 16) % 8;
            exp_hs = (hc >= 10 && hc < 13) ? 1'b0 : 1'b1;
            exp_vs = (ln >= 5 && ln < 7) ? 1'b0 : 1'b1;
            exp_de = (hc < 8) && (ln < 4);
            exp_fs = (n % 128 == 0);
            exp_dr = ((n % 16) < 8) && (((n / 16) % 8) < 4);
            n_cmp++; if (x0 !== 12'(n % 16)) begin n_err++; $display("FAIL frame_x clk=%0d got %0d exp %0d", n, x0, n % 16); end
            n_cmp++; if (y0 !== 12'((n / 16) % 8)) begin n_err++; $display("FAIL frame_y clk=%0d got %0d exp %0d", n, y0, (n / 16) % 8); end
            n_cmp++; if (hs0 !== exp_hs) begin n_err++; $display("FAIL frame_hsync clk=%0d got %b exp %b", n, hs0, exp_hs); end
            n_cmp++; if (vs0 !== exp_vs) begin n_err++; $display("FAIL frame_vsync clk=%0d got %b exp %b", n, vs0, exp_vs); end
            n_cmp++; if (de0 !== exp_de) begin n_err++; $display("FAIL frame_de clk=%0d got %b exp %b", n, de0, exp_de); end
            n_cmp++; if (dr0 !== exp_dr) begin n_err++; $display("FAIL frame_de_req clk=%0d got %b exp %b", n, dr0, exp_dr); end
            n_cmp++; if (fs0 !== exp_fs) begin n_err++; $display("FAIL frame_start clk=%0d got %b exp %b", n, fs0, exp_fs); end
            if (fs0 === 1'b1) begin
                pulses++;
                if (first_pulse < 0) first_pulse = n;
            end
        end
        n_cmp++; if (pulses != 2) begin n_err++; $display("FAIL frame_pulse_count got %0d exp 2", pulses); end
        n_cmp++; if (first_pulse != 128) begin n_err++; $display("FAIL frame_first_pulse got %0d exp 128", first_pulse); end
    endtask

    // Colour and de follow de_req by one clk; blanked to zero outside active area.
    task automatic test_color_align();
        logic prev;
        do_reset();
        prev = dr0;
        for (int n = 1; n <= 128; n++) begin
            step();
            n_cmp++; if (de0 !== prev) begin n_err++; $display("FAIL color_de clk=%0d got %b exp %b", n, de0, prev); end
            n_cmp++; if (r0 !== (prev ? 8'hA5 : 8'h00)) begin n_err++; $display("FAIL color_red clk=%0d got %h exp %h", n, r0, prev ? 8'hA5 : 8'h00); end
            n_cmp++; if (g0 !== (prev ? 8'h3C : 8'h00)) begin n_err++; $display("FAIL color_green clk=%0d got %h exp %h", n, g0, prev ? 8'h3C : 8'h00); end
            n_cmp++; if (b0 !== (prev ? 8'h5A : 8'h00)) begin n_err++; $display("FAIL color_blue clk=%0d got %h exp %h", n, b0, prev ? 8'h5A : 8'h00); end
            prev = dr0;
        end
    endtask

    // CLK_DIV=4, active-high h_sync: x held 4 clks, 64-clk line, 12 high clks per line.
    task automatic test_clkdiv();
        int hc, hi0, hi1;
        logic exp_hs;
        hi0 = 0;
        hi1 = 0;
        do_reset();
        for (int n = 1; n <= 128; n++) begin
            step();
            hc = ((n - 1) / 4) % 16;
            exp_hs = (hc >= 10 && hc < 13);
            n_cmp++; if (x1 !== 12'((n / 4) % 16)) begin n_err++; $display("FAIL div_x clk=%0d got %0d exp %0d", n, x1, (n / 4) % 16); end
            n_cmp++; if (y1 !== 12'((n / 64) % 8)) begin n_err++; $display("FAIL div_y clk=%0d got %0d exp %0d", n, y1, (n / 64) % 8); end
            n_cmp++; if (hs1 !== exp_hs) begin n_err++; $display("FAIL div_hsync clk=%0d got %b exp %b", n, hs1, exp_hs); end
            if (hs1 === 1'b1) begin
                if (n <= 64) hi0++; else hi1++;
            end
        end
        n_cmp++; if (hi0 != 12) begin n_err++; $display("FAIL div_hs_width_line0 got %0d exp 12", hi0); end
        n_cmp++; if (hi1 != 12) begin n_err++; $display("FAIL div_hs_width_line1 got %0d exp 12", hi1); end
    endtask

    // en low for 20 clks at x=5: everything frozen, then resume at x=6.
    task automatic test_en_freeze();
        do_reset();
        repeat (5) step();
        n_cmp++; if (x0 !== 12'd5) begin n_err++; $display("FAIL freeze_pre_x got %0d exp 5", x0); end
        en = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            n_cmp++; if (x0 !== 12'd5 || y0 !== 12'd0) begin n_err++; $display("FAIL freeze_xy got %0d,%0d exp 5,0", x0, y0); end
            n_cmp++; if (hs0 !== 1'b1) begin n_err++; $display("FAIL freeze_hsync got %b exp 1", hs0); end
            n_cmp++; if (r0 !== 8'hA5 || de0 !== 1'b1) begin n_err++; $display("FAIL freeze_color got %h/%b exp a5/1", r0, de0); end
            n_cmp++; if (fs0 !== 1'b0) begin n_err++; $display("FAIL freeze_fs got %b exp 0", fs0); end
        end
        en = 1'b1;
        step();
        n_cmp++; if (x0 !== 12'd6) begin n_err++; $display("FAIL freeze_resume_x got %0d exp 6", x0); end
    endtask

    // Reset pulse while h_sync is asserted returns to (0,0) with syncs idle next clk.
    task automatic test_rst_mid_sync();
        do_reset();
        repeat (12) step();
        n_cmp++; if (hs0 !== 1'b0) begin n_err++; $display("FAIL midsync_pre_hsync got %b exp 0", hs0); end
        rst = 1'b1;
        step();
        n_cmp++; if (x0 !== 12'd0 || y0 !== 12'd0) begin n_err++; $display("FAIL midsync_xy got %0d,%0d exp 0,0", x0, y0); end
        n_cmp++; if (hs0 !== 1'b1) begin n_err++; $display("FAIL midsync_hsync got %b exp 1", hs0); end
        n_cmp++; if (de0 !== 1'b0 || r0 !== 8'h00) begin n_err++; $display("FAIL midsync_de_red got %b/%h exp 0/00", de0, r0); end
        rst = 1'b0;
        step();
        n_cmp++; if (x0 !== 12'd1) begin n_err++; $display("FAIL midsync_restart_x got %0d exp 1", x0); end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    // Colour bars: output after clk n reflects bar at x=n-1.
    task automatic test_pattern();
        pattern_sel = 1'b1;
        do_reset();
        step();
        n_cmp++; if ({r0, g0, b0} !== 24'h000000) begin n_err++; $display("FAIL pattern_x0 got %h exp 000000", {r0, g0, b0}); end
        repeat (4) step();
        n_cmp++; if ({r0, g0, b0} !== 24'hFF0000) begin n_err++; $display("FAIL pattern_x4 got %h exp ff0000", {r0, g0, b0}); end
        repeat (3) step();
        n_cmp++; if ({r0, g0, b0} !== 24'hFFFFFF) begin n_err++; $display("FAIL pattern_x7 got %h exp ffffff", {r0, g0, b0}); end
        pattern_sel = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_color_align();
        test_clkdiv();
        test_en_freeze();
        test_rst_mid_sync();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
